// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared fixed-point constants, accumulator sizing, signed
//                saturation helper and the matmul engine state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int c_fixed_point_width = 16;
    localparam int c_frac_bits         = 8;

    // EMPTY: no weights held; READY: weights held, pipeline empty;
    // BUSY: at least one vector in flight.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_READY = 2'd1,
        ST_BUSY  = 2'd2
    } engine_state_t;

    // Full product plus enough headroom to add `rows` products without overflow.
    function automatic int acc_width(input int word_w, input int rows);
        return 2 * word_w + $clog2(rows);
    endfunction

    // Clamp a sign-extended value into the signed range of word_w bits.
    // Callers detect saturation by comparing the result with the input.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int               word_w);
        logic signed [63:0] v_max;
        logic signed [63:0] v_min;
        logic signed [63:0] res;
        v_max = (64'sd1 <<< (word_w - 1)) - 64'sd1;
        v_min = -(64'sd1 <<< (word_w - 1));
        res   = v;
        if (v > v_max) begin
            res = v_max;
        end else if (v < v_min) begin
            res = v_min;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pe.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pe
//  Description : Weight-stationary processing element. Holds one weight,
//                multiplies the activation arriving from the west and adds
//                the partial sum arriving from the north.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_en           - pipeline advance (low = global stall)
//                i_w_load, i_w  - weight load strobe and value
//                i_a, o_a       - activation in (west) / forwarded (east)
//                i_ps, o_ps     - partial sum in (north) / out (south)
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_pe
    import nn_pkg::*;
#(
    parameter int WORD_W = c_fixed_point_width,
    parameter int ACC_W  = acc_width(c_fixed_point_width, 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_w_load,
    input  logic [WORD_W-1:0] i_w,
    input  logic [WORD_W-1:0] i_a,
    input  logic [ACC_W-1:0]  i_ps,
    output logic [WORD_W-1:0] o_a,
    output logic [ACC_W-1:0]  o_ps
);

    logic        [WORD_W-1:0]   r_w;
    logic signed [2*WORD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic        [ACC_W-1:0]    w_sum;

    assign w_prod     = $signed(i_a) * $signed(r_w);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_sum      = i_ps + w_prod_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w  <= '0;
            o_a  <= '0;
            o_ps <= '0;
        end else begin
            // Weight loads happen only while the pipeline is empty, so they
            // need not follow the stall enable.
            if (i_w_load) begin
                r_w <= i_w;
            end
            if (i_en) begin
                o_a  <= i_a;
                o_ps <= w_sum;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_matmul_engine.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_matmul_engine
//  Description : Weight-stationary systolic array computing s = a x W in
//                signed fixed point, with input skew / output deskew so the
//                caller sees whole vectors, and a global stall on backpressure.
//  Ports       : clk_in, rst_in                      - clock, sync reset
//                weights_valid_in/ready_out/weights_in - weight matrix load
//                act_valid_in/ready_out/activations_in - activation vector
//                sum_valid_out/sum_ready_in/sum_out    - result vector
//                sat_out                               - per-column clamp flag
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_matmul_engine
    import nn_pkg::*;
#(
    parameter int SYSTOLIC_ARRAY_ROWS = 8,
    parameter int SYSTOLIC_ARRAY_COLS = 8,
    parameter int FIXED_POINT_WIDTH   = c_fixed_point_width,
    parameter int FRAC_BITS           = c_frac_bits
) (
    input  logic                                                          clk_in,
    input  logic                                                          rst_in,
    input  logic                                                          weights_valid_in,
    output logic                                                          weights_ready_out,
    input  logic [SYSTOLIC_ARRAY_ROWS*SYSTOLIC_ARRAY_COLS*FIXED_POINT_WIDTH-1:0] weights_in,
    input  logic                                                          act_valid_in,
    output logic                                                          act_ready_out,
    input  logic [SYSTOLIC_ARRAY_ROWS*FIXED_POINT_WIDTH-1:0]              activations_in,
    output logic                                                          sum_valid_out,
    input  logic                                                          sum_ready_in,
    output logic [SYSTOLIC_ARRAY_COLS*FIXED_POINT_WIDTH-1:0]              sum_out,
    output logic [SYSTOLIC_ARRAY_COLS-1:0]                                sat_out
);

    localparam int c_rows  = SYSTOLIC_ARRAY_ROWS;
    localparam int c_cols  = SYSTOLIC_ARRAY_COLS;
    localparam int c_w     = FIXED_POINT_WIDTH;
    localparam int c_acc_w = acc_width(FIXED_POINT_WIDTH, SYSTOLIC_ARRAY_ROWS);
    localparam int c_lat   = c_rows + c_cols;
    localparam int c_cnt_w = $clog2(c_lat + 1);

    engine_state_t            r_state;
    logic [c_cnt_w-1:0]       r_inflight;
    logic [c_lat-1:0]         r_vld;
    logic [c_cols*c_w-1:0]    r_sum;
    logic [c_cols-1:0]        r_sat;

    logic w_adv;
    logic w_act_fire;
    logic w_wt_fire;
    logic w_sum_fire;

    // Whole pipeline advances unless a valid result is being held back.
    assign w_adv      = !(r_vld[c_lat-1] && !sum_ready_in);
    assign w_act_fire = act_valid_in && act_ready_out;
    assign w_wt_fire  = weights_valid_in && weights_ready_out;
    assign w_sum_fire = sum_valid_out && sum_ready_in;

    // Ready signals are decoded from the registered state; they must react to
    // same-cycle stall and weight contention, so they cannot be registered.
    assign weights_ready_out = !rst_in && (r_state == ST_EMPTY || r_state == ST_READY);
    assign act_ready_out     = !rst_in && w_adv &&
                               (r_state == ST_BUSY ||
                                (r_state == ST_READY && !weights_valid_in));

    assign sum_valid_out = r_vld[c_lat-1];
    assign sum_out       = r_sum;
    assign sat_out       = r_sat;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ST_EMPTY;
            r_inflight <= '0;
        end else begin
            if (w_act_fire && !w_sum_fire) begin
                r_inflight <= r_inflight + c_cnt_w'(1);
            end else if (!w_act_fire && w_sum_fire) begin
                r_inflight <= r_inflight - c_cnt_w'(1);
            end
            case (r_state)
                ST_EMPTY: if (w_wt_fire) r_state <= ST_READY;
                ST_READY: if (w_act_fire) r_state <= ST_BUSY;
                ST_BUSY: begin
                    if (w_sum_fire && !w_act_fire && r_inflight == c_cnt_w'(1)) begin
                        r_state <= ST_READY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // Valid token travels alongside its vector: skew + array + deskew + output reg.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld <= {r_vld[c_lat-2:0], w_act_fire};
        end
    end

    // ---------------- input skew: row r delayed by r cycles ----------------
    logic [c_w-1:0] w_act_gated [c_rows];
    logic [c_w-1:0] w_row_act   [c_rows];

    for (genvar r = 0; r < c_rows; r++) begin : g_skew
        // Bubbles carry zeros so idle slots never contribute to a wavefront.
        assign w_act_gated[r] = w_act_fire ? activations_in[r*c_w +: c_w] : '0;
        if (r == 0) begin : g_direct
            assign w_row_act[r] = w_act_gated[r];
        end else begin : g_delay
            logic [c_w-1:0] r_line [r];
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    for (int k = 0; k < r; k++) r_line[k] <= '0;
                end else if (w_adv) begin
                    r_line[0] <= w_act_gated[r];
                    for (int k = 1; k < r; k++) r_line[k] <= r_line[k-1];
                end
            end
            assign w_row_act[r] = r_line[r-1];
        end
    end

    // ---------------- PE grid: activations east, partial sums south --------
    logic [c_w-1:0]     w_a  [c_rows][c_cols+1];
    logic [c_acc_w-1:0] w_ps [c_rows+1][c_cols];

    for (genvar r = 0; r < c_rows; r++) begin : g_west
        assign w_a[r][0] = w_row_act[r];
    end
    for (genvar c = 0; c < c_cols; c++) begin : g_north
        assign w_ps[0][c] = '0;
    end

    for (genvar r = 0; r < c_rows; r++) begin : g_row
        for (genvar c = 0; c < c_cols; c++) begin : g_col
            systolic_pe #(
                .WORD_W (c_w),
                .ACC_W  (c_acc_w)
            ) u_pe (
                .clk      (clk_in),
                .rst      (rst_in),
                .i_en     (w_adv),
                .i_w_load (w_wt_fire),
                .i_w      (weights_in[(r*c_cols+c)*c_w +: c_w]),
                .i_a      (w_a[r][c]),
                .i_ps     (w_ps[r][c]),
                .o_a      (w_a[r][c+1]),
                .o_ps     (w_ps[r+1][c])
            );
        end
    end

    // ---------------- output deskew + rescale / saturate -------------------
    logic [c_acc_w-1:0] w_col     [c_cols];
    logic [c_w-1:0]     w_col_val [c_cols];
    logic [c_cols-1:0]  w_col_sat;

    for (genvar c = 0; c < c_cols; c++) begin : g_deskew
        // Column c finishes c cycles after column 0; later columns wait less.
        localparam int c_depth = c_cols - 1 - c;
        if (c_depth == 0) begin : g_direct
            assign w_col[c] = w_ps[c_rows][c];
        end else begin : g_delay
            logic [c_acc_w-1:0] r_line [c_depth];
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    for (int k = 0; k < c_depth; k++) r_line[k] <= '0;
                end else if (w_adv) begin
                    r_line[0] <= w_ps[c_rows][c];
                    for (int k = 1; k < c_depth; k++) r_line[k] <= r_line[k-1];
                end
            end
            assign w_col[c] = r_line[c_depth-1];
        end

        // Arithmetic shift floors toward -inf before clamping to W bits.
        logic signed [c_acc_w-1:0] w_shift;
        logic signed [63:0]        w_wide;
        assign w_shift      = $signed(w_col[c]) >>> FRAC_BITS;
        assign w_wide       = 64'(w_shift);
        assign w_col_val[c] = FIXED_POINT_WIDTH'(saturate(w_wide, FIXED_POINT_WIDTH));
        assign w_col_sat[c] = (saturate(w_wide, FIXED_POINT_WIDTH) != w_wide);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sum <= '0;
            r_sat <= '0;
        end else if (w_adv) begin
            for (int c = 0; c < c_cols; c++) r_sum[c*c_w +: c_w] <= w_col_val[c];
            r_sat <= w_col_sat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_matmul_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_matmul_engine
//  Description : Directed bench for systolic_matmul_engine with a scoreboard
//                fed by an independent fixed-point golden model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_matmul_engine;

    localparam int R  = 8;
    localparam int C  = 8;
    localparam int W  = 16;
    localparam int FB = 8;

    typedef struct packed {
        logic [C*W-1:0] sum;
        logic [C-1:0]   sat;
    } exp_t;

    logic               clk_in           = 1'b0;
    logic               rst_in           = 1'b1;
    logic               weights_valid_in = 1'b0;
    logic               act_valid_in     = 1'b0;
    logic               sum_ready_in     = 1'b1;
    logic [R*C*W-1:0]   weights_in       = '0;
    logic [R*W-1:0]     activations_in   = '0;
    logic               weights_ready_out;
    logic               act_ready_out;
    logic               sum_valid_out;
    logic [C*W-1:0]     sum_out;
    logic [C-1:0]       sat_out;

    systolic_matmul_engine #(
        .SYSTOLIC_ARRAY_ROWS (R),
        .SYSTOLIC_ARRAY_COLS (C),
        .FIXED_POINT_WIDTH   (W),
        .FRAC_BITS           (FB)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .weights_valid_in  (weights_valid_in),
        .weights_ready_out (weights_ready_out),
        .weights_in        (weights_in),
        .act_valid_in      (act_valid_in),
        .act_ready_out     (act_ready_out),
        .activations_in    (activations_in),
        .sum_valid_out     (sum_valid_out),
        .sum_ready_in      (sum_ready_in),
        .sum_out           (sum_out),
        .sat_out           (sat_out)
    );

    always #5 clk_in = ~clk_in;

    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   popped   = 0;
    int   cyc      = 0;
    int   hs_cyc   = 0;
    logic rand_ready = 1'b0;
    exp_t sb_q [$];

    logic signed [W-1:0] tb_w [R][C];
    logic signed [W-1:0] tb_a [R];

    always @(posedge clk_in) cyc <= cyc + 1;

    // Downstream backpressure source.
    always @(posedge clk_in) begin
        #1;
        sum_ready_in = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    task automatic chk(input string tag, input logic [C*W-1:0] obs, input logic [C*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t golden();
        exp_t   e;
        longint acc;
        longint sh;
        e = '0;
        for (int c = 0; c < C; c++) begin
            acc = 0;
            for (int r = 0; r < R; r++) acc += longint'(tb_a[r]) * longint'(tb_w[r][c]);
            sh = acc >>> FB;
            if (sh > 32767) begin
                e.sum[c*W +: W] = 16'h7FFF;
                e.sat[c]        = 1'b1;
            end else if (sh < -32768) begin
                e.sum[c*W +: W] = 16'h8000;
                e.sat[c]        = 1'b1;
            end else begin
                e.sum[c*W +: W] = sh[W-1:0];
            end
        end
        return e;
    endfunction

    task automatic drive_weights();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                weights_in[(r*C+c)*W +: W] = tb_w[r][c];
    endtask

    task automatic drive_act();
        for (int r = 0; r < R; r++) activations_in[r*W +: W] = tb_a[r];
    endtask

    task automatic set_all_weights(input logic [W-1:0] v);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) tb_w[r][c] = v;
    endtask

    task automatic rand_weights();
        int t;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                t = $urandom_range(0, 2047);
                tb_w[r][c] = W'(t - 1024);
            end
    endtask

    task automatic rand_act();
        int t;
        for (int r = 0; r < R; r++) begin
            t = $urandom_range(0, 2047);
            tb_a[r] = W'(t - 1024);
        end
    endtask

    task automatic load_weights();
        bit done = 1'b0;
        drive_weights();
        weights_valid_in = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_in);
            if (weights_ready_out) done = 1'b1;
        end
        chk("weights_handshake", done, 1);
        @(posedge clk_in);
        #1;
        weights_valid_in = 1'b0;
    endtask

    task automatic send_vec();
        bit done = 1'b0;
        drive_act();
        act_valid_in = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_in);
            if (act_ready_out) done = 1'b1;
        end
        chk("act_handshake", done, 1);
        if (done) begin
            sb_q.push_back(golden());
            pushed++;
            hs_cyc = cyc;
        end
        @(posedge clk_in);
        #1;
        act_valid_in = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1000 && sb_q.size() != 0; i++) @(negedge clk_in);
        chk("drain", sb_q.size(), 0);
        repeat (2) @(posedge clk_in);
        #1;
    endtask

    // Output monitor: scoreboard compare on handshake, stability while stalled.
    logic           prev_stall = 1'b0;
    logic [C*W-1:0] prev_sum   = '0;
    logic [C-1:0]   prev_sat   = '0;
    exp_t           got_exp;

    always @(negedge clk_in) begin
        if (rst_in) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", sum_valid_out, 1);
                chk("stall_sum_held", sum_out, prev_sum);
                chk("stall_sat_held", sat_out, prev_sat);
            end
            if (sum_valid_out && sum_ready_in) begin
                checks++;
                assert (sb_q.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_result observed=%0h expected=none", sum_out);
                end
                if (sb_q.size() != 0) begin
                    got_exp = sb_q.pop_front();
                    popped++;
                    chk("result_sum", sum_out, got_exp.sum);
                    chk("result_sat", sat_out, got_exp.sat);
                end
            end
            prev_stall = sum_valid_out && !sum_ready_in;
            prev_sum   = sum_out;
            prev_sat   = sat_out;
        end
    end

    initial begin
        int             lat;
        int             popped_before;
        int             discarded;
        int             spurious;
        logic [C*W-1:0] id_exp;

        set_all_weights('0);
        for (int r = 0; r < R; r++) tb_a[r] = '0;

        // Reset behaviour
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_weights_ready_low", weights_ready_out, 0);
        chk("rst_act_ready_low", act_ready_out, 0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("post_rst_weights_ready", weights_ready_out, 1);
        chk("post_rst_sum_valid", sum_valid_out, 0);
        chk("post_rst_sum_out", sum_out, '0);
        chk("post_rst_sat_out", sat_out, '0);

        // Activation offered before any weights
        for (int r = 0; r < R; r++) tb_a[r] = 16'h0100;
        drive_act();
        act_valid_in = 1'b1;
        repeat (3) begin
            @(negedge clk_in);
            chk("act_ready_in_empty", act_ready_out, 0);
        end
        @(posedge clk_in);
        #1;
        act_valid_in = 1'b0;

        // Identity weights, ramp activations, latency
        set_all_weights('0);
        for (int r = 0; r < R; r++) tb_w[r][r] = 16'h0100;
        load_weights();
        for (int r = 0; r < R; r++) tb_a[r] = W'(256 * (r + 1));
        send_vec();
        lat = -1;
        for (int i = 0; i < 60 && lat < 0; i++) begin
            @(negedge clk_in);
            if (sum_valid_out) lat = cyc - hs_cyc;
        end
        chk("latency", lat, 16);
        for (int c = 0; c < C; c++) id_exp[c*W +: W] = W'(256 * (c + 1));
        chk("identity_sum", sum_out, id_exp);
        chk("identity_sat", sat_out, '0);
        wait_drain();

        // All ones
        set_all_weights(16'h0100);
        load_weights();
        for (int r = 0; r < R; r++) tb_a[r] = 16'h0100;
        send_vec();
        wait_drain();

        // Positive and negative saturation
        set_all_weights(16'h7FFF);
        load_weights();
        for (int r = 0; r < R; r++) tb_a[r] = 16'h7FFF;
        send_vec();
        wait_drain();
        set_all_weights(16'h8000);
        load_weights();
        send_vec();
        wait_drain();

        // Simultaneous weight and activation offers in READY
        rand_weights();
        drive_weights();
        rand_act();
        drive_act();
        weights_valid_in = 1'b1;
        act_valid_in     = 1'b1;
        @(negedge clk_in);
        chk("both_valid_act_ready", act_ready_out, 0);
        chk("both_valid_weights_ready", weights_ready_out, 1);
        @(posedge clk_in);
        #1;
        weights_valid_in = 1'b0;
        send_vec();
        wait_drain();

        // 20 back-to-back vectors under random backpressure
        rand_weights();
        load_weights();
        popped_before = popped;
        rand_ready    = 1'b1;
        for (int v = 0; v < 20; v++) begin
            rand_act();
            send_vec();
        end
        wait_drain();
        rand_ready = 1'b0;
        chk("stress_result_count", popped - popped_before, 20);

        // Reset with 5 vectors in flight
        for (int v = 0; v < 5; v++) begin
            rand_act();
            send_vec();
        end
        rst_in    = 1'b1;
        discarded = sb_q.size();
        sb_q.delete();
        @(negedge clk_in);
        chk("midop_rst_weights_ready_low", weights_ready_out, 0);
        @(posedge clk_in);
        #1;
        rst_in   = 1'b0;
        spurious = 0;
        repeat (40) begin
            @(negedge clk_in);
            if (sum_valid_out) spurious++;
        end
        chk("no_spurious_valid", spurious, 0);
        act_valid_in = 1'b1;
        @(negedge clk_in);
        chk("post_midop_act_ready", act_ready_out, 0);
        chk("post_midop_weights_ready", weights_ready_out, 1);
        @(posedge clk_in);
        #1;
        act_valid_in = 1'b0;
        chk("midop_discarded", discarded, 5);
        chk("scoreboard_balance", popped + discarded, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_matmul_engine.md
SYSTOLIC_MATMUL_ENGINE -- requirements
Module: systolic_matmul_engine

Interface
REQ-001 SHALL have parameter SYSTOLIC_ARRAY_ROWS, default 8, meaning activation-vector length / PE rows.
REQ-002 SHALL have parameter SYSTOLIC_ARRAY_COLS, default 8, meaning output-vector length / PE columns.
REQ-003 SHALL have parameter FIXED_POINT_WIDTH, default 16, meaning signed fixed-point word width.
REQ-004 SHALL have parameter FRAC_BITS, default 8, meaning fractional bits (Q8.8 by default; 0x0100 = 1.0).
REQ-005 SHALL have port clk_in, input, 1, meaning the single clock; all logic on posedge.
REQ-006 SHALL have port rst_in, input, 1, meaning the reset; synchronous, active-high.
REQ-007 SHALL have port weights_valid_in, input, 1, meaning the weight matrix is offered.
REQ-008 SHALL have port weights_ready_out, output, 1, meaning the weights can be accepted.
REQ-009 SHALL have port weights_in, input, ROWS x COLS x W, meaning weight W[r][c].
REQ-010 SHALL have port act_valid_in, input, 1, meaning an activation vector is offered.
REQ-011 SHALL have port act_ready_out, output, 1, meaning the activation vector can be accepted.
REQ-012 SHALL have port activations_in, input, ROWS x W, meaning activation a[r].
REQ-013 SHALL have port sum_valid_out, output, 1, meaning the result vector is valid.
REQ-014 SHALL have port sum_ready_in, input, 1, meaning downstream accepts the result.
REQ-015 SHALL have port sum_out, output, COLS x W, meaning result s[c].
REQ-016 SHALL have port sat_out, output, COLS, meaning per-column saturation occurred for this result.

Function
REQ-017 SHALL compute s[c] = sum over r of a[r]*W[r][c] per accepted activation vector, weight-stationary.
REQ-018 SHALL use a full 2W-bit signed product and an accumulator of 2W+clog2(ROWS) bits, with no intermediate overflow.
REQ-019 SHALL form each output as accumulator arithmetic-shifted right by FRAC_BITS (truncate toward -inf), saturated to the signed W range, and SHALL set sat_out[c] when clamped.
REQ-020 SHALL skew inputs internally (row r delayed r cycles) and deskew outputs (column c aligned), so callers present and receive whole, unskewed vectors.
REQ-021 SHALL use the FSM states EMPTY (no weights), READY (weights held, pipeline empty) and BUSY (>=1 vector in flight).
REQ-022 SHALL use these transitions: EMPTY->READY on weight handshake; READY->BUSY on activation handshake; BUSY->READY when the last in-flight result handshakes out and no new vector is accepted that cycle.
REQ-023 SHALL assert weights_ready_out only in EMPTY or READY; weights are captured in one cycle and are visible to the next accepted vector.
REQ-024 SHALL give weights priority when weights_valid_in and act_valid_in are both high in READY: act_ready_out is 0 that cycle.
REQ-025 SHALL hold act_ready_out at 0 in EMPTY and when stalled; otherwise it is 1, accepting one vector per cycle (full throughput).
REQ-026 SHALL make latency exactly ROWS+COLS cycles from activation handshake to sum_valid_out with no stall (16 by default).
REQ-027 SHALL, while sum_valid_out=1 and sum_ready_in=0, freeze the whole pipeline (global stall), holding sum_out and sat_out stable with no data loss.
REQ-028 SHALL keep sum_valid_out independent of sum_ready_in in the same cycle.
REQ-029 SHALL make the weight input invalid in BUSY: weights_valid_in is ignored and in-flight results use the old weights.

Reset
REQ-030 SHALL, on rst_in, go to EMPTY and clear sum_valid_out, sum_out, sat_out, act_ready_out, all PE registers and the weights.
REQ-031 SHALL hold weights_ready_out at 0 during rst_in and at 1 the cycle after deassertion.
REQ-032 SHALL discard in-flight vectors on reset mid-operation, with no spurious sum_valid_out afterwards.

Structure
REQ-033 SHALL place in nn_pkg: the fixed-point width/frac constants, the accumulator-width function, the saturate function and the FSM state enum.
REQ-034 SHALL use one sub-module, systolic_pe (weight register, MAC, activation/partial-sum forwarding, stall enable), instantiated ROWS x COLS.
REQ-035 SHALL implement skew/deskew as shift-register delay lines in the top level.

Verification
REQ-036 SHALL cover: identity weights (W[r][r]=0x0100), a[r]=0x0100*(r+1) -> s[c]=0x0100*(c+1), sum_valid_out exactly 16 cycles after the handshake.
REQ-037 SHALL cover: all weights 0x0100, all a=0x0100 -> every s[c]=0x0800, sat_out=0.
REQ-038 SHALL cover: all weights 0x7FFF, all a=0x7FFF -> s[c]=0x7FFF, sat_out=all ones; weights 0x8000 with a=0x7FFF -> 0x8000, saturated.
REQ-039 SHALL cover: 20 back-to-back vectors with sum_ready_in randomly low -> 20 results in order, matching the golden model, none lost or duplicated, outputs stable while stalled.
REQ-040 SHALL cover: act_valid_in before any weight load -> act_ready_out=0; simultaneous weights/act valid in READY -> weights accepted, act_ready_out=0 that cycle.
REQ-041 SHALL cover: rst_in pulsed with 5 vectors in flight -> no sum_valid_out for 40 cycles, state EMPTY, weights_ready_out=1.
